// File: rtl/pocket_video_pkg.sv
// Shared types and helpers for the Pocket video output formatter.
package pocket_video_pkg;

    localparam int unsigned RGB_W  = 24;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned GAP_W  = 4;

    typedef logic [RGB_W-1:0] rgb24_t;

    // Upper bits of the end-of-line slot word
    localparam logic [RGB_W-SLOT_W-1:0] EOL_PREFIX = 21'd0;

    // End-of-line word carrying the scaler slot in its low bits
    function automatic rgb24_t eol_word(input logic [SLOT_W-1:0] slot);
        return {EOL_PREFIX, slot};
    endfunction

endpackage

// File: rtl/pocket_video_formatter_if.sv
// Video bus between scanlines_generator and the Pocket video pins.
// master: drives the level-type in_* side and observes video_*.
// slave : the formatter, consuming in_* and driving video_*.
interface pocket_video_formatter_if;
    import pocket_video_pkg::*;

    rgb24_t in_rgb;
    logic   in_hs;
    logic   in_vs;
    logic   in_de;

    rgb24_t video_rgb;
    logic   video_de;
    logic   video_hs;
    logic   video_vs;
    logic   video_skip;

    modport master (
        output in_rgb, in_hs, in_vs, in_de,
        input  video_rgb, video_de, video_hs, video_vs, video_skip
    );

    modport slave (
        input  in_rgb, in_hs, in_vs, in_de,
        output video_rgb, video_de, video_hs, video_vs, video_skip
    );
endinterface

// File: rtl/pocket_sync_edge.sv
// Registers a sync level, normalises it to active-high and flags its leading edge.
// History resets to the inactive level so reset release never fakes an edge.
module pocket_sync_edge #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sync,
    output logic o_edge_c
);

    logic w_norm;
    logic r_level;
    logic r_level_d;

    assign w_norm = ACTIVE_HIGH ? i_sync : ~i_sync;

    // Capture normalised level and one cycle of history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level   <= w_norm;
            r_level_d <= r_level;
        end
    end

    assign o_edge_c = r_level & ~r_level_d;

endmodule

// File: rtl/pocket_video_formatter.sv
// Final Pocket video stage: level syncs -> one-cycle APF pulses, RGB blanking,
// end-of-line slot word after each active line. Fixed 2-cycle latency.
// Optional pixel-enable/skip support is built when POCKET_VIDEO_SKIP_EN is defined.
module pocket_video_formatter
    import pocket_video_pkg::*;
#(
    parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
    parameter int unsigned VS_HS_GAP        = 3
) (
    input  logic                     clk_vid,
    input  logic                     reset,
    pocket_video_formatter_if.slave  vid,
    input  logic [SLOT_W-1:0]        scaler_slot
`ifdef POCKET_VIDEO_SKIP_EN
    ,
    input  logic                     ce_pix
`endif
);

    localparam int unsigned GAP_MAX = (1 << GAP_W) - 1;

    // Reject a gap that cannot be held in the counter or would never separate pulses
    if ((VS_HS_GAP < 1) || (VS_HS_GAP > GAP_MAX)) begin : g_gap_range
        $error("pocket_video_formatter: VS_HS_GAP=%0d outside 1..%0d", VS_HS_GAP, GAP_MAX);
    end

    // Stage 1 registers
    rgb24_t            r_rgb_s1;
    logic              r_de_s1;
    logic              r_de_s1_d;
    logic [SLOT_W-1:0] r_slot_s1;
`ifdef POCKET_VIDEO_SKIP_EN
    logic              r_ce_s1;
`endif

    // Frame/line state
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_hs_pend;
    logic [SLOT_W-1:0] r_slot_q;
    logic              r_line_had_de;

    // Output registers
    rgb24_t            r_video_rgb;
    logic              r_video_de;
    logic              r_video_hs;
    logic              r_video_vs;
`ifdef POCKET_VIDEO_SKIP_EN
    logic              r_video_skip;
`endif

    logic              w_hs_edge;
    logic              w_vs_edge;
    logic              w_de_fall;
    logic              w_eol;
    logic              w_de_out;
    logic [GAP_W-1:0]  w_gap_next;
    logic              w_hs_fire;
    logic              w_hs_pend_next;

    pocket_sync_edge #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_hs_edge (
        .clk      (clk_vid),
        .reset    (reset),
        .i_sync   (vid.in_hs),
        .o_edge_c (w_hs_edge)
    );

    pocket_sync_edge #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_vs_edge (
        .clk      (clk_vid),
        .reset    (reset),
        .i_sync   (vid.in_vs),
        .o_edge_c (w_vs_edge)
    );

    // Stage 1: register pixel data, de history and the slot index
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_rgb_s1  <= '0;
            r_de_s1   <= 1'b0;
            r_de_s1_d <= 1'b0;
            r_slot_s1 <= '0;
`ifdef POCKET_VIDEO_SKIP_EN
            r_ce_s1   <= 1'b0;
`endif
        end else begin
            r_rgb_s1  <= vid.in_rgb;
            r_de_s1   <= vid.in_de;
            r_de_s1_d <= r_de_s1;
            r_slot_s1 <= scaler_slot;
`ifdef POCKET_VIDEO_SKIP_EN
            r_ce_s1   <= ce_pix;
`endif
        end
    end

    assign w_de_fall = r_de_s1_d & ~r_de_s1;
    assign w_eol     = w_de_fall & r_line_had_de;

`ifdef POCKET_VIDEO_SKIP_EN
    assign w_de_out  = r_de_s1 & r_ce_s1;
`else
    assign w_de_out  = r_de_s1;
`endif

    // Gap countdown after vs and hs deferral; a deferred hs fires as the count lands on 0
    always_comb begin
        w_gap_next     = r_gap_cnt;
        w_hs_fire      = 1'b0;
        w_hs_pend_next = r_hs_pend;
        if (w_vs_edge) begin
            w_gap_next = GAP_W'(VS_HS_GAP);
        end else if (r_gap_cnt != '0) begin
            w_gap_next = r_gap_cnt - GAP_W'(1);
        end
        w_hs_fire      = (w_hs_edge | r_hs_pend) & (w_gap_next == '0);
        w_hs_pend_next = (w_hs_edge | r_hs_pend) & ~w_hs_fire;
    end

    // Stage 2: frame/line state and registered pin outputs
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_gap_cnt     <= '0;
            r_hs_pend     <= 1'b0;
            r_slot_q      <= '0;
            r_line_had_de <= 1'b0;
            r_video_rgb   <= '0;
            r_video_de    <= 1'b0;
            r_video_hs    <= 1'b0;
            r_video_vs    <= 1'b0;
`ifdef POCKET_VIDEO_SKIP_EN
            r_video_skip  <= 1'b0;
`endif
        end else begin
            r_gap_cnt  <= w_gap_next;
            r_hs_pend  <= w_hs_pend_next;
            r_video_hs <= w_hs_fire;
            r_video_vs <= w_vs_edge;
            r_video_de <= w_de_out;
`ifdef POCKET_VIDEO_SKIP_EN
            r_video_skip <= r_de_s1 & ~r_ce_s1;
`endif
            if (w_vs_edge) begin
                r_slot_q <= r_slot_s1;
            end

            if (r_de_s1) begin
                r_video_rgb <= r_rgb_s1;
            end else if (w_eol) begin
                r_video_rgb <= eol_word(r_slot_q);
            end else begin
                r_video_rgb <= '0;
            end

            if (r_de_s1) begin
                r_line_had_de <= 1'b1;
            end else if (w_hs_edge | w_eol) begin
                r_line_had_de <= 1'b0;
            end
        end
    end

    assign vid.video_rgb  = r_video_rgb;
    assign vid.video_de   = r_video_de;
    assign vid.video_hs   = r_video_hs;
    assign vid.video_vs   = r_video_vs;
`ifdef POCKET_VIDEO_SKIP_EN
    assign vid.video_skip = r_video_skip;
`else
    assign vid.video_skip = 1'b0;
`endif

endmodule
